// File: rtl/rv_lsu_if.sv
// Bundle of request, response and data-memory signals around the load/store unit.
// The slave modport is the LSU itself; the master modport is whoever drives
// requests and models the memory (execute stage plus memory, or a bench).
interface rv_lsu_if #(
  parameter int XLEN = 32
);
  localparam int NBYTES = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_misaligned;
  logic              resp_illegal;

  logic              mem_read;
  logic              mem_write;
  logic [XLEN-1:0]   mem_address;
  logic [XLEN-1:0]   mem_wdata;
  logic [NBYTES-1:0] mem_byte_enable;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_misaligned, resp_illegal,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_misaligned, resp_illegal,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/rv_lsu.sv
// Load/store unit between execute and the data memory port, XLEN 32 or 64.
// One request is outstanding at a time. Legal aligned requests go to memory
// with a beat-aligned address and byte mask; illegal or misaligned requests
// are answered directly without touching memory. Load data is shifted down
// from its byte lanes and sign- or zero-extended to XLEN.
module rv_lsu #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  rv_lsu_if.slave bus
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [OFFW-1:0]   off_q;
  logic [4:0]        rd_q;

  logic [OFFW-1:0]   req_off;
  logic              req_legal;
  logic              req_misaligned;
  logic [NBYTES-1:0] size_mask;

  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   keep;
  logic              sign;
  logic [XLEN-1:0]   load_ext;

  // Classify the incoming request: legality for this XLEN, alignment, lane mask
  always_comb begin
    req_off        = bus.req_addr[OFFW-1:0];
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    size_mask      = '1;
    if (bus.req_is_store) begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        3'b011:                 req_legal = (XLEN == 64);
        default:                req_legal = 1'b0;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        3'b011, 3'b110:                         req_legal = (XLEN == 64);
        default:                                req_legal = 1'b0;
      endcase
    end
    case (bus.req_funct3[1:0])
      2'b00: begin
        req_misaligned = 1'b0;
        size_mask      = NBYTES'(1);
      end
      2'b01: begin
        req_misaligned = req_off[0];
        size_mask      = NBYTES'(3);
      end
      2'b10: begin
        req_misaligned = |req_off[1:0];
        size_mask      = NBYTES'(15);
      end
      default: begin
        req_misaligned = |req_off;
        size_mask      = '1;
      end
    endcase
  end

  // Bring the addressed bytes of the returned beat down to bit 0 and extend them
  always_comb begin
    raw  = bus.mem_rdata >> {off_q, 3'b000};
    keep = '1;
    sign = 1'b0;
    case (funct3_q[1:0])
      2'b00: begin
        keep = XLEN'(8'hFF);
        sign = raw[7];
      end
      2'b01: begin
        keep = XLEN'(16'hFFFF);
        sign = raw[15];
      end
      2'b10: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sign = raw[31];
      end
      default: begin
        keep = '1;
        sign = 1'b0;
      end
    endcase
    if (funct3_q[2]) sign = 1'b0;
    load_ext = (raw & keep) | ({XLEN{sign}} & ~keep);
  end

  // Request/memory/response sequencing with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      bus.req_ready       <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_rd         <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_illegal    <= 1'b0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= '0;
      is_store_q          <= 1'b0;
      funct3_q            <= '0;
      off_q               <= '0;
      rd_q                <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            is_store_q    <= bus.req_is_store;
            funct3_q      <= bus.req_funct3;
            off_q         <= req_off;
            rd_q          <= bus.req_rd;
            bus.req_ready <= 1'b0;
            if (!req_legal || req_misaligned) begin
              state               <= RESP;
              bus.resp_valid      <= 1'b1;
              bus.resp_rdata      <= '0;
              bus.resp_rd         <= bus.req_rd;
              bus.resp_illegal    <= !req_legal;
              bus.resp_misaligned <= req_legal && req_misaligned;
            end else begin
              state               <= ACCESS;
              bus.mem_read        <= !bus.req_is_store;
              bus.mem_write       <= bus.req_is_store;
              bus.mem_address     <= {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              bus.mem_wdata       <= bus.req_wdata << {req_off, 3'b000};
              bus.mem_byte_enable <= bus.req_is_store ? (size_mask << req_off) : '1;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_resp) begin
            state               <= RESP;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.resp_valid      <= 1'b1;
            bus.resp_rdata      <= is_store_q ? '0 : load_ext;
            bus.resp_rd         <= rd_q;
            bus.resp_illegal    <= 1'b0;
            bus.resp_misaligned <= 1'b0;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
